charmap_num_writer: RTL and testbench

- Writer side of the character-map interface: converts a binary value into four right-justified decimal character codes and writes them into a character-map RAM row.
- Code set matches the char ROM: 0x0–0x9 are digits, 0xF is blank.
- Used to update the frequency-axis labels, and any numeric readout, at run time instead of fixing them in a case table.
- Downstream, the pixel renderer reads the map unchanged.

---
 rtl/charmap_num_writer.sv | 121 ++++++++++++
 tb/tb_charmap_num_writer.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/charmap_num_writer.sv
// Binary-to-decimal label writer for the character map.
// Double-dabbles a value, then writes four right-justified codes.
module charmap_num_writer #(
  parameter int VAL_W = 14,
  parameter int NDIG = 4,
  parameter logic [3:0] BLANK = 4'hF
) (
  input  logic             ck,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [VAL_W-1:0] req_value,
  input  logic [3:0]       req_row,
  output logic             wr_en,
  output logic [6:0]       wr_addr,
  output logic [3:0]       wr_data,
  output logic             busy,
  output logic             done
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] CONV  = 2'd1;
  localparam logic [1:0] WRITE = 2'd2;

  localparam int CW = $clog2(VAL_W + 1);
  localparam logic [CW-1:0] LAST = CW'(VAL_W - 1);
  localparam logic [VAL_W-1:0] MAXV = VAL_W'(9999);
  localparam logic [1:0] LCOL = 2'(NDIG - 1);

  logic [1:0]       state;
  logic [CW-1:0]    cnt;
  logic [VAL_W-1:0] bin;
  logic [15:0]      bcd;
  logic [15:0]      adj;
  logic [15:0]      bcd_nxt;
  logic [3:0]       row;
  logic [1:0]       col;
  logic [1:0]       ncol;
  logic             seen;
  logic [3:0]       d0;
  logic [3:0]       dig;
  logic             sup;
  logic             unused;

  always_comb begin
    adj = bcd;
    for (int i = 0; i < 4; i++) begin
      if (bcd[4*i +: 4] >= 4'd5)
        adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
  end

  assign bcd_nxt = {adj[14:0], bin[VAL_W-1]};
  assign unused  = adj[15];
  assign d0      = bcd_nxt[15:12];
  assign dig     = bcd[15:12];
  assign ncol    = col + 2'd1;
  // Leading zeros blank until a nonzero digit; units always shown
  assign sup     = !seen && dig == 4'd0 && ncol != LCOL;

  assign req_ready = state == IDLE;
  assign busy      = state != IDLE;

  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      bin     <= '0;
      bcd     <= '0;
      row     <= '0;
      col     <= '0;
      seen    <= 1'b0;
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (req_valid) begin
            state <= CONV;
            cnt   <= '0;
            bcd   <= '0;
            bin   <= (req_value > MAXV) ? MAXV : req_value;
            row   <= req_row;
          end
        end
        CONV: begin
          bcd <= bcd_nxt;
          bin <= bin << 1;
          cnt <= cnt + 1'b1;
          if (cnt == LAST) begin
            state   <= WRITE;
            col     <= '0;
            bcd     <= bcd_nxt << 4;
            seen    <= d0 != 4'd0;
            wr_en   <= 1'b1;
            wr_addr <= {row, 3'd0};
            wr_data <= (d0 == 4'd0) ? BLANK : d0;
          end
        end
        WRITE: begin
          if (col == LCOL) begin
            state <= IDLE;
            wr_en <= 1'b0;
            done  <= 1'b1;
          end else begin
            col     <= ncol;
            bcd     <= bcd << 4;
            seen    <= seen | (dig != 4'd0);
            wr_addr <= {row, 1'b0, ncol};
            wr_data <= sup ? BLANK : dig;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_charmap_num_writer.sv
// Directed bench for charmap_num_writer.
// Table vectors plus back-to-back and mid-write reset sequences.
module tb_charmap_num_writer;

  logic        ck;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [13:0] req_value;
  logic [3:0]  req_row;
  logic        wr_en;
  logic [6:0]  wr_addr;
  logic [3:0]  wr_data;
  logic        busy;
  logic        done;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [13:0] value;
    logic [3:0]  row;
    logic [15:0] codes;
  } vec_t;

  vec_t vecs[11];

  charmap_num_writer dut (
    .ck(ck), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_value(req_value), .req_row(req_row),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .done(done)
  );

  initial ck = 1'b0;
  always #5 ck = ~ck;

  task automatic chk(input string nm, input int k,
                     input logic een, input logic [6:0] ea,
                     input logic [3:0] ed, input logic edone,
                     input logic eidle);
    checks++;
    if (wr_en !== een || done !== edone || req_ready !== eidle ||
        busy !== !eidle ||
        (een && (wr_addr !== ea || wr_data !== ed))) begin
      errors++;
      $display("FAIL %s cyc %0d: got en=%b addr=%h data=%h done=%b rdy=%b busy=%b want en=%b addr=%h data=%h done=%b rdy=%b",
               nm, k, wr_en, wr_addr, wr_data, done, req_ready, busy,
               een, ea, ed, edone, eidle);
    end
  endtask

  function automatic logic [3:0] code_at(input logic [15:0] codes,
                                         input int col);
    logic [15:0] sh;
    sh = codes >> (4 * (3 - col));
    return sh[3:0];
  endfunction

  task automatic run_vec(input string nm, input logic [13:0] v,
                         input logic [3:0] r, input logic [15:0] codes);
    logic       een;
    logic [6:0] ea;
    logic [3:0] ed;
    @(negedge ck);
    req_valid = 1'b1;
    req_value = v;
    req_row   = r;
    @(posedge ck);
    #1;
    req_valid = 1'b0;
    for (int k = 1; k <= 19; k++) begin
      @(negedge ck);
      if (k == 5) req_value = v ^ 14'h3FFF;
      een = (k >= 15 && k <= 18);
      ea  = '0;
      ed  = '0;
      if (een) begin
        ea = {r, 3'(k - 15)};
        ed = code_at(codes, k - 15);
      end
      chk(nm, k, een, ea, ed, k == 19, k == 19);
    end
  endtask

  task automatic run_b2b();
    logic       een;
    logic [6:0] ea;
    logic [3:0] ed;
    logic [15:0] codes;
    int col;
    @(negedge ck);
    req_valid = 1'b1;
    req_value = 14'd1400;
    req_row   = 4'd2;
    @(posedge ck);
    #1;
    for (int k = 1; k <= 38; k++) begin
      @(negedge ck);
      if (k == 3) req_value = 14'd1200;
      if (k == 20) req_valid = 1'b0;
      een   = (k >= 15 && k <= 18) || (k >= 34 && k <= 37);
      col   = (k >= 34) ? k - 34 : k - 15;
      codes = (k >= 34) ? 16'h1200 : 16'h1400;
      ea = '0;
      ed = '0;
      if (een) begin
        ea = {4'd2, 3'(col)};
        ed = code_at(codes, col);
      end
      chk("b2b", k, een, ea, ed, k == 19 || k == 38, k == 19 || k == 38);
    end
  endtask

  task automatic run_rst_mid();
    @(negedge ck);
    req_valid = 1'b1;
    req_value = 14'd2200;
    req_row   = 4'd9;
    @(posedge ck);
    #1;
    req_valid = 1'b0;
    for (int k = 1; k <= 15; k++) @(negedge ck);
    @(posedge ck);
    #1;
    chk("rst_pre", 16, 1'b1, 7'h49, 4'd2, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("rst_async", 16, 1'b0, 7'h00, 4'd0, 1'b0, 1'b1);
    #4;
    rst_n = 1'b1;
    for (int k = 0; k < 25; k++) begin
      @(negedge ck);
      chk("rst_after", k, 1'b0, 7'h00, 4'd0, 1'b0, 1'b1);
    end
  endtask

  initial begin
    vecs[0]  = '{14'd2200,  4'd0,  16'h2200};
    vecs[1]  = '{14'd800,   4'd7,  16'hF800};
    vecs[2]  = '{14'd0,     4'd11, 16'hFFF0};
    vecs[3]  = '{14'd12345, 4'd1,  16'h9999};
    vecs[4]  = '{14'd9999,  4'd2,  16'h9999};
    vecs[5]  = '{14'd1000,  4'd15, 16'h1000};
    vecs[6]  = '{14'd42,    4'd6,  16'hFF42};
    vecs[7]  = '{14'd5,     4'd3,  16'hFFF5};
    vecs[8]  = '{14'd16383, 4'd4,  16'h9999};
    vecs[9]  = '{14'd10000, 4'd5,  16'h9999};
    vecs[10] = '{14'd307,   4'd12, 16'hF307};

    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_value = '0;
    req_row   = '0;
    #2;
    checks++;
    if (req_ready !== 1'b1 || wr_en !== 1'b0 || wr_addr !== 7'h00 ||
        wr_data !== 4'h0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset: got rdy=%b en=%b addr=%h data=%h busy=%b done=%b want 1 0 00 0 0 0",
               req_ready, wr_en, wr_addr, wr_data, busy, done);
    end
    repeat (2) @(negedge ck);
    rst_n = 1'b1;

    for (int i = 0; i < 11; i++)
      run_vec($sformatf("vec%0d", i), vecs[i].value, vecs[i].row,
              vecs[i].codes);

    run_b2b();
    run_rst_mid();
    run_vec("fresh", 14'd4096, 4'd8, 16'h4096);

    for (int k = 0; k < 50; k++) begin
      @(negedge ck);
      chk("idle", k, 1'b0, 7'h00, 4'd0, 1'b0, 1'b1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
